// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length and FSM encodings, Nk/Nr
// lookups and GF(2^8) helpers used by the word S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_e;

  // Deepest schedule (AES-256): 4 * (14 + 1) words.
  localparam int unsigned MAX_WORDS = 60;

  function automatic logic [3:0] nk_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_e kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  // Key size in bits; 0 for the reserved encoding.
  function automatic int unsigned key_bits_of(input key_len_e kl);
    case (kl)
      KL_128:  return 128;
      KL_192:  return 192;
      KL_256:  return 256;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int unsigned k = 0; k < 6; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// One key-schedule word step: w[i] = w[i-Nk] ^ f(w[i-1]).
// A single word S-box is shared between the RotWord path (j==0) and the
// AES-256 mid-block SubWord path (j==4).
module aes_key_word_step
  import aes_pkg::*;
(
  input  logic [31:0] prev_word,
  input  logic [31:0] back_word,
  input  logic [2:0]  j,
  input  logic [3:0]  nk,
  input  logic [7:0]  rcon,
  output logic [31:0] next_word
);

  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;

  aes_sbox_word u_sbox (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  // Select S-box input and form the mixed temp word.
  always_comb begin
    sub_in = prev_word;
    temp   = prev_word;
    if (j == 3'd0) begin
      sub_in = {prev_word[23:0], prev_word[31:24]};
      temp   = sub_out ^ {rcon, 24'h000000};
    end else if (nk == 4'd8 && j == 3'd4) begin
      temp   = sub_out;
    end
    next_word = back_word ^ temp;
  end

endmodule

// File: rtl/aes_sbox_word.sv
// 32-bit word S-box: four parallel byte substitutions.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Byte-wise substitution.
  always_comb begin
    word_out = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word_out[8*b +: 8] = sbox_byte(word_in[8*b +: 8]);
    end
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key expander: one schedule word per cycle into
// an internal store; any round key is then readable by index.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter bit          RK_OUT_REG   = 1'b1
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid
);

  localparam int unsigned SCHED_WORDS = (MAX_KEY_BITS >= 256) ? MAX_WORDS :
                                        (MAX_KEY_BITS >= 192) ? 52 : 44;

  state_e      state_q, state_d;
  logic [3:0]  nk_q, nk_d;
  logic [3:0]  nr_q, nr_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        sched_ok_q, sched_ok_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];

  logic [31:0] store_q [SCHED_WORDS];

  logic [31:0] key_w [8];
  logic        mode_ok;
  logic        load_en;
  logic        exp_en;
  logic [5:0]  last_idx;
  logic [31:0] next_word;

  key_len_e    kl;
  assign kl = key_len_e'(key_len);

  // Split the left-aligned key into words w[0..7].
  always_comb begin
    for (int unsigned m = 0; m < 8; m++) begin
      key_w[m] = key_in[32*(7-m) +: 32];
    end
  end

  assign mode_ok  = (kl != KL_RSVD) && (key_bits_of(kl) <= MAX_KEY_BITS);
  assign last_idx = 6'({nr_q, 2'b00} + 6'd3);

  aes_key_word_step u_step (
    .prev_word (win_q[0]),
    .back_word (win_q[3'(nk_q - 4'd1)]),
    .j         (j_q),
    .nk        (nk_q),
    .rcon      (rcon_q),
    .next_word (next_word)
  );

  // Next-state logic: IDLE accepts/rejects, LOAD seeds, EXPAND steps.
  always_comb begin
    state_d    = state_q;
    nk_d       = nk_q;
    nr_d       = nr_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    sched_ok_d = sched_ok_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    win_d      = win_q;
    load_en    = 1'b0;
    exp_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_ok) begin
            nk_d    = nk_of(kl);
            nr_d    = nr_of(kl);
            state_d = ST_LOAD;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        // Window slot 0 holds the newest word, slot Nk-1 the oldest needed.
        for (int unsigned k = 0; k < 8; k++) begin
          win_d[k] = (k < 32'(nk_q)) ? key_w[3'(32'(nk_q) - 1 - k)] : '0;
        end
        i_d        = 6'(nk_q);
        j_d        = '0;
        rcon_d     = 8'h01;
        sched_ok_d = 1'b0;
        state_d    = ST_EXPAND;
      end
      ST_EXPAND: begin
        exp_en   = 1'b1;
        win_d[0] = next_word;
        for (int unsigned k = 1; k < 8; k++) begin
          win_d[k] = win_q[k-1];
        end
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        j_d = (j_q == 3'(nk_q - 4'd1)) ? '0 : j_q + 3'd1;
        i_d = i_q + 6'd1;
        if (i_q == last_idx) begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          sched_ok_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and window registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      i_q        <= '0;
      j_q        <= '0;
      rcon_q     <= 8'h01;
      sched_ok_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      win_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      nk_q       <= nk_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      sched_ok_q <= sched_ok_d;
      done_q     <= done_d;
      err_q      <= err_d;
      win_q      <= win_d;
    end
  end

  // Schedule store: Nk key words in LOAD, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (k < 32'(nk_q)) store_q[6'(k)] <= key_w[k];
      end
    end else if (exp_en) begin
      store_q[i_q] <= next_word;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

  logic         rd_ok;
  logic [5:0]   rd_base;
  logic [127:0] rd_key;

  // Round-key selection, forced to word 0 when the index is not readable.
  always_comb begin
    rd_ok   = sched_ok_q && (state_q == ST_IDLE) && (rk_idx <= nr_q);
    rd_base = rd_ok ? {rk_idx, 2'b00} : '0;
    rd_key  = {store_q[rd_base], store_q[rd_base + 6'd1],
               store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
  end

  if (RK_OUT_REG) begin : g_rk_reg
    logic         rk_valid_q, rk_valid_d;
    logic [127:0] rk_out_q, rk_out_d;

    // Registered read; a start being accepted this cycle invalidates the
    // key so rk_valid never shows high during LOAD.
    always_comb begin
      rk_valid_d = rd_ok && (state_d == ST_IDLE);
      rk_out_d   = rk_valid_d ? rd_key : '0;
    end

    // Read-port output register.
    always_ff @(posedge clk) begin
      if (reset) begin
        rk_valid_q <= 1'b0;
        rk_out_q   <= '0;
      end else begin
        rk_valid_q <= rk_valid_d;
        rk_out_q   <= rk_out_d;
      end
    end

    assign rk_valid = rk_valid_q;
    assign rk_out   = rk_out_q;
  end else begin : g_rk_comb
    assign rk_valid = rd_ok;
    assign rk_out   = rd_ok ? rd_key : '0;
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander using FIPS-197 key vectors.
module tb_aes_key_expander;

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int           dq[$];
  int           eq[$];
  int           rq_issue[$];
  bit           rq_v[$];
  logic [127:0] rq_val[$];
  string        rq_name[$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_cafef00d};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h5555aaaa_33cc33cc};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expander #(
    .MAX_KEY_BITS (256),
    .RK_OUT_REG   (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .rk_valid (rk_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents done/err/read data.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cycle=%0d", cyc);
      end else begin
        int e;
        e = dq.pop_front();
        if (cyc != e) begin
          failures++;
          $display("FAIL done_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
    if (err) begin
      checks++;
      if (eq.size() == 0) begin
        failures++;
        $display("FAIL err_unexpected cycle=%0d", cyc);
      end else begin
        int e;
        e = eq.pop_front();
        if (cyc != e) begin
          failures++;
          $display("FAIL err_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
    if (busy && rk_valid) begin
      checks++;
      failures++;
      $display("FAIL rk_valid_while_busy got=1 exp=0 cycle=%0d", cyc);
    end
    if (rq_issue.size() > 0 && rq_issue[0] == cyc - 1) begin
      bit           v;
      logic [127:0] val;
      string        nm;
      void'(rq_issue.pop_front());
      v   = rq_v.pop_front();
      val = rq_val.pop_front();
      nm  = rq_name.pop_front();
      checks++;
      if (rk_valid !== v || rk_out !== val) begin
        failures++;
        $display("FAIL %s got valid=%0b key=%h exp valid=%0b key=%h", nm, rk_valid, rk_out, v, val);
      end
    end
  end

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
    end
  endtask

  task automatic start_run(input logic [1:0] kl, input logic [255:0] key);
    @(negedge clk);
    key_len = kl;
    key_in  = key;
    start   = 1'b1;
    dq.push_back(cyc + 42 + 6 * int'(kl));
    @(negedge clk);
    start = 1'b0;
    check_bit("busy_in_load", busy, 1'b1);
    @(negedge clk);
    key_in = ~key;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle_timeout got=busy exp=idle limit=%0d", limit);
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, input bit v, input logic [127:0] val, input string nm);
    @(negedge clk);
    rk_idx = idx;
    rq_issue.push_back(cyc);
    rq_v.push_back(v);
    rq_val.push_back(val);
    rq_name.push_back(nm);
  endtask

  task automatic aes128_reads();
    read_rk(4'd0,  1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, "k128_rk0");
    read_rk(4'd1,  1'b1, 128'ha0fafe1788542cb123a339392a6c7605, "k128_rk1");
    read_rk(4'd2,  1'b1, 128'hf2c295f27a96b9435935807a7359f67f, "k128_rk2");
    read_rk(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "k128_rk10");
    read_rk(4'd11, 1'b0, '0, "k128_rk11_invalid");
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    key_len = '0;
    key_in  = '0;
    rk_idx  = '0;
    repeat (3) @(negedge clk);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_err", err, 1'b0);
    check_bit("reset_rk_valid", rk_valid, 1'b0);
    checks++;
    if (rk_out !== '0) begin
      failures++;
      $display("FAIL reset_rk_out got=%h exp=0", rk_out);
    end
    reset = 1'b0;

    // AES-128 with a start pulse mid-run that must be ignored.
    start_run(2'd0, K128);
    repeat (5) @(negedge clk);
    start = 1'b1; key_len = 2'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);
    aes128_reads();

    // AES-192.
    start_run(2'd1, K192);
    wait_idle(100);
    read_rk(4'd0,  1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5, "k192_rk0");
    read_rk(4'd1,  1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, "k192_rk1");
    read_rk(4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202, "k192_rk12");
    read_rk(4'd13, 1'b0, '0, "k192_rk13_invalid");

    // AES-256.
    start_run(2'd2, K256);
    wait_idle(100);
    read_rk(4'd0,  1'b1, 128'h603deb1015ca71be2b73aef0857d7781, "k256_rk0");
    read_rk(4'd1,  1'b1, 128'h1f352c073b6108d72d9810a30914dff4, "k256_rk1");
    read_rk(4'd2,  1'b1, 128'h9ba354118e6925afa51a8b5f2067fcde, "k256_rk2");
    read_rk(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "k256_rk14");
    read_rk(4'd15, 1'b0, '0, "k256_rk15_invalid");

    // Reserved key length: err pulse, schedule untouched.
    @(negedge clk);
    key_len = 2'd3;
    start   = 1'b1;
    eq.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    check_bit("err_busy_low", busy, 1'b0);
    @(negedge clk);
    check_bit("err_one_cycle", err, 1'b0);
    read_rk(4'd14, 1'b1, 128'hfe4890d1e6188d0b046df344706c631e, "after_err_rk14");

    // Reset during EXPAND cycle 20.
    @(negedge clk);
    key_len = 2'd0;
    key_in  = K128;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_bit("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_bit("reset_mid_busy", busy, 1'b0);
    check_bit("reset_mid_rk_valid", rk_valid, 1'b0);
    read_rk(4'd1, 1'b0, '0, "reset_mid_rk1_invalid");
    repeat (30) @(negedge clk);
    start_run(2'd0, K128);
    wait_idle(100);
    aes128_reads();

    // start held high: back-to-back runs exactly 42 cycles apart.
    @(negedge clk);
    key_len = 2'd0;
    key_in  = K128;
    start   = 1'b1;
    dq.push_back(cyc + 42);
    dq.push_back(cyc + 84);
    repeat (84) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_bit("held_start_idle", busy, 1'b0);
    read_rk(4'd10, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "held_rk10");

    repeat (4) @(negedge clk);
    checks++;
    if (dq.size() != 0 || eq.size() != 0 || rq_issue.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations got done=%0d err=%0d reads=%0d exp=0",
               dq.size(), eq.size(), rq_issue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Sequential AES key-schedule engine supporting 128/192/256-bit keys (FIPS-197), selected per operation.
- Expands one 32-bit word per cycle into an internal schedule store.
- The cipher datapath then reads any 128-bit round key by index.
- Multi-mode, iterative successor to the team's single-step combinational 128-bit round-key stage; it sits between key load and the round pipeline.

Parameters:
- MAX_KEY_BITS, 256: largest supported key size (128/192/256). Sets schedule depth (44/52/60 words); modes above it raise err.
- RK_OUT_REG, 1: 1 = rk_out registered (1-cycle read latency); 0 = combinational read.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request expansion; sampled only in IDLE
- key_len  in  2  0=128, 1=192, 2=256, 3=reserved
- key_in  in  256  key, left-aligned: w[0] = key_in[255:224]; unused low bits ignored
- busy  out  1  high in LOAD/EXPAND
- done  out  1  one-cycle pulse when schedule complete
- err  out  1  one-cycle pulse on rejected start
- rk_idx  in  4  round-key index 0..Nr
- rk_out  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}
- rk_valid  out  1  rk_out holds a valid key for the sampled rk_idx

Behaviour:
- Nk = 4/6/8 and Nr = 10/12/14 for key_len 0/1/2. Nw = 4*(Nr+1).
- Reset values: busy=0, done=0, err=0, rk_valid=0, rk_out=0, state=IDLE, sched_ok=0. Schedule store is not cleared.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE, start=1, legal mode: latch Nk/Nr, go to LOAD.
- IDLE, start=1, key_len=3 or mode above MAX_KEY_BITS: err=1 for one cycle, stay in IDLE, sched_ok unchanged.
- LOAD (1 cycle):
  - write w[0..Nk-1] from key_in into the store and into an 8x32 sliding window;
  - i=Nk, j=0 (i mod Nk), rcon=0x01;
  - clear sched_ok; go to EXPAND.
- EXPAND (one word per cycle), with temp = w[i-1]:
  - j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon) (0x80 becomes 0x1b).
  - Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - Write w[i] to store and window; i++, j wraps at Nk.
- EXPAND exit: when i == Nw-1 is written, go to IDLE; next cycle done=1 and sched_ok=1.
- EXPAND length: 40/46/52 cycles. Start-to-done: 42/48/54 cycles counting the start cycle.
- Cycle budget: exactly one S-box word lookup per cycle.
- start is ignored while busy; no queuing.
- start asserted in the same cycle as done: accepted, because the FSM is already in IDLE.
- Read path (RK_OUT_REG=1): rk_idx is sampled each cycle. Next cycle:
  - rk_valid = sched_ok && rk_idx <= Nr;
  - rk_out = the selected key, or 0 when not valid.
- Read path (RK_OUT_REG=0): same decision, combinational.
- rk_valid is 0 throughout LOAD/EXPAND.
- Reset mid-operation: return to IDLE next edge, sched_ok=0, no done pulse.
- key_in is only sampled in LOAD; changes afterwards have no effect.

Decomposition:
- Package aes_pkg holds:
  - key-length encodings KL_128/KL_192/KL_256;
  - NK/NR lookup functions;
  - xtime function;
  - MAX_WORDS constant (60).
- One sub-module aes_key_word_step (combinational), containing:
  - inputs: prev word, back word, j, Nk, rcon;
  - output: next word;
  - internals: RotWord, the team's existing 32-bit word S-box instance, rcon XOR.
- The FSM, counters, window and store stay in aes_key_expander.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done 42 cycles after start; rk_idx=1 -> a0fafe1788542cb123a339392a6c7605; rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at 48 cycles; rk_idx=12 -> e98ba06f448c773c8ecc720401002202; rk_idx=13 -> rk_valid=0, rk_out=0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done at 54 cycles; rk_idx=14 -> fe4890d1e6188d0b046df344706c631e; rk_idx=0 -> key_in[255:128].
- key_len=3 in IDLE -> err pulses 1 cycle; busy stays 0; previous schedule still readable with rk_valid=1.
- Reset asserted at EXPAND cycle 20 -> busy=0 next cycle, rk_valid=0, no done; a following AES-128 run reproduces the vectors above.
- start held high throughout -> second run starts in the done cycle; start pulses during busy are ignored; done spacing is exactly 42 cycles (AES-128).
